// File: rtl/arf074b064e1r1w0cbbehsaa4acw_bist_addr_seq_if.sv
// Bus between the BIST controller and the address sequencer.
// Optional abort input exists only when
// ARF074B064E1R1W0CBBEHSAA4ACW_BIST_ADDR_SEQ_ABORT_EN is defined.
interface arf074b064e1r1w0cbbehsaa4acw_bist_addr_seq_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64
);
  // Controller -> sequencer
  logic                  start;
  logic                  dir;
  logic                  step_en;
`ifdef ARF074B064E1R1W0CBBEHSAA4ACW_BIST_ADDR_SEQ_ABORT_EN
  logic                  abort;
`endif

  // Sequencer -> controller / wordline mux
  logic [ADDR_WIDTH-1:0] addr;
  logic [DEPTH-1:0]      wl_sel;
  logic                  addr_vld;
  logic                  last;
  logic                  busy;
  logic                  done;

`ifdef ARF074B064E1R1W0CBBEHSAA4ACW_BIST_ADDR_SEQ_ABORT_EN
  modport master (
    output start, dir, step_en, abort,
    input  addr, wl_sel, addr_vld, last, busy, done
  );

  modport slave (
    input  start, dir, step_en, abort,
    output addr, wl_sel, addr_vld, last, busy, done
  );
`else
  modport master (
    output start, dir, step_en,
    input  addr, wl_sel, addr_vld, last, busy, done
  );

  modport slave (
    input  start, dir, step_en,
    output addr, wl_sel, addr_vld, last, busy, done
  );
`endif
endinterface

// File: rtl/arf074b064e1r1w0cbbehsaa4acw_bist_addr_seq.sv
// March-style BIST address sequencer with registered one-hot wordline decode.
// One pass walks DEPTH rows ascending or descending, one row per step_en,
// then pulses done for a single cycle. Every output comes from a flop.
// Optional feature macro: ARF074B064E1R1W0CBBEHSAA4ACW_BIST_ADDR_SEQ_ABORT_EN
// (adds an abort input that cancels a running pass without a done pulse).
module arf074b064e1r1w0cbbehsaa4acw_bist_addr_seq #(
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64
) (
  input logic clk,
  input logic rst,
  arf074b064e1r1w0cbbehsaa4acw_bist_addr_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Highest legal row; also the terminal row of an ascending pass.
  localparam logic [ADDR_WIDTH-1:0] LP_TOP = ADDR_WIDTH'(DEPTH - 1);

  state_t                r_state;
  state_t                w_state_next;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic [DEPTH-1:0]      r_wl_sel;
  logic [DEPTH-1:0]      w_wl_sel_next;
  logic [DEPTH-1:0]      w_dec;
  logic                  r_dir;
  logic                  w_dir_next;
  logic                  r_vld;
  logic                  w_vld_next;
  logic                  r_last;
  logic                  w_last_next;
  logic                  r_busy;
  logic                  w_busy_next;
  logic                  r_done;
  logic                  w_done_next;
  logic [ADDR_WIDTH-1:0] w_term_next;
  logic                  w_abort;

`ifdef ARF074B064E1R1W0CBBEHSAA4ACW_BIST_ADDR_SEQ_ABORT_EN
  assign w_abort = bus.abort;
`else
  // Without the abort feature a pass can only end through DONE or rst.
  assign w_abort = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    w_state_next = r_state;
    w_dir_next   = r_dir;
    w_addr_next  = r_addr;
    w_vld_next   = r_vld;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_addr_next = '0;
        w_vld_next  = 1'b0;
        w_busy_next = 1'b0;
        if (bus.start) begin
          // Direction is captured once here and held for the whole pass.
          w_dir_next   = bus.dir;
          w_addr_next  = bus.dir ? LP_TOP : '0;
          w_vld_next   = 1'b1;
          w_busy_next  = 1'b1;
          w_state_next = ST_RUN;
        end
      end

      ST_RUN: begin
        if (w_abort) begin
          w_addr_next  = '0;
          w_vld_next   = 1'b0;
          w_busy_next  = 1'b0;
          w_state_next = ST_IDLE;
        end else if (bus.step_en) begin
          if (r_last) begin
            // Stepping off the terminal row ends the pass; no wrap.
            w_addr_next  = '0;
            w_vld_next   = 1'b0;
            w_busy_next  = 1'b1;
            w_done_next  = 1'b1;
            w_state_next = ST_DONE;
          end else if (r_dir) begin
            w_addr_next = r_addr - ADDR_WIDTH'(1);
          end else begin
            w_addr_next = r_addr + ADDR_WIDTH'(1);
          end
        end
        // step_en low: everything holds (stall).
      end

      ST_DONE: begin
        w_addr_next  = '0;
        w_vld_next   = 1'b0;
        w_busy_next  = 1'b0;
        w_state_next = ST_IDLE;
      end

      default: begin
        w_addr_next  = '0;
        w_vld_next   = 1'b0;
        w_busy_next  = 1'b0;
        w_state_next = ST_IDLE;
      end
    endcase

    // Terminal row follows the direction that will be in force next cycle,
    // so last is valid on the very first row of a pass as well.
    w_term_next   = w_dir_next ? '0 : LP_TOP;
    w_last_next   = w_vld_next && (w_addr_next == w_term_next);
    w_wl_sel_next = w_vld_next ? w_dec : '0;
  end

  // One comparator per physical row; rows >= DEPTH simply have no bit,
  // so out-of-range addresses can never light a wordline.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dec
      assign w_dec[gi] = (w_addr_next == ADDR_WIDTH'(gi));
    end
  endgenerate

  // Output registers; addr and wl_sel update on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r_wl_sel <= '0;
      r_dir    <= 1'b0;
      r_vld    <= 1'b0;
      r_last   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_addr   <= w_addr_next;
      r_wl_sel <= w_wl_sel_next;
      r_dir    <= w_dir_next;
      r_vld    <= w_vld_next;
      r_last   <= w_last_next;
      r_busy   <= w_busy_next;
      r_done   <= w_done_next;
    end
  end

  assign bus.addr     = r_addr;
  assign bus.wl_sel   = r_wl_sel;
  assign bus.addr_vld = r_vld;
  assign bus.last     = r_last;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_arf074b064e1r1w0cbbehsaa4acw_bist_addr_seq.sv
// Directed bench for the BIST address sequencer: DEPTH=64 and DEPTH=40 instances.
module tb_arf074b064e1r1w0cbbehsaa4acw_bist_addr_seq;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  arf074b064e1r1w0cbbehsaa4acw_bist_addr_seq_if #(.ADDR_WIDTH(6), .DEPTH(64)) bus64 ();
  arf074b064e1r1w0cbbehsaa4acw_bist_addr_seq_if #(.ADDR_WIDTH(6), .DEPTH(40)) bus40 ();

  arf074b064e1r1w0cbbehsaa4acw_bist_addr_seq #(.ADDR_WIDTH(6), .DEPTH(64)) u_dut64 (
    .clk (clk),
    .rst (rst),
    .bus (bus64)
  );

  arf074b064e1r1w0cbbehsaa4acw_bist_addr_seq #(.ADDR_WIDTH(6), .DEPTH(40)) u_dut40 (
    .clk (clk),
    .rst (rst),
    .bus (bus40)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus64.start   = 1'b0;
    bus64.dir     = 1'b0;
    bus64.step_en = 1'b0;
    bus40.start   = 1'b0;
    bus40.dir     = 1'b0;
    bus40.step_en = 1'b0;
`ifdef ARF074B064E1R1W0CBBEHSAA4ACW_BIST_ADDR_SEQ_ABORT_EN
    bus64.abort   = 1'b0;
    bus40.abort   = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Invariants on every cycle once out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus64.addr_vld) chk("inv_onehot", 64'($onehot(bus64.wl_sel)), 64'd1);
      else                chk("inv_wl_zero", bus64.wl_sel, 64'd0);
      if (bus64.done)     chk("inv_done_novld", 64'(bus64.addr_vld), 64'd0);
      if (bus64.last)     chk("inv_last_vld", 64'(bus64.addr_vld), 64'd1);
    end
  end

  // Full unstalled pass on the 64-row instance.
  task automatic run64(input logic d);
    logic [63:0] one;
    int          a;
    bus64.dir     = d;
    bus64.start   = 1'b1;
    bus64.step_en = 1'b1;
    tick();
    bus64.start = 1'b0;
    for (int k = 0; k < 64; k++) begin
      a   = d ? 63 - k : k;
      one = 64'd1 << a;
      chk("p64_addr", 64'(bus64.addr), 64'(a));
      chk("p64_wl", bus64.wl_sel, one);
      chk("p64_last", 64'(bus64.last), 64'(k == 63));
      chk("p64_vld", 64'(bus64.addr_vld), 64'd1);
      chk("p64_busy", 64'(bus64.busy), 64'd1);
      chk("p64_done", 64'(bus64.done), 64'd0);
      tick();
    end
    chk("p64_done_pulse", 64'(bus64.done), 64'd1);
    chk("p64_done_busy", 64'(bus64.busy), 64'd1);
    chk("p64_done_vld", 64'(bus64.addr_vld), 64'd0);
    chk("p64_done_addr", 64'(bus64.addr), 64'd0);
    chk("p64_done_last", 64'(bus64.last), 64'd0);
    bus64.step_en = 1'b0;
    tick();
    chk("p64_idle_busy", 64'(bus64.busy), 64'd0);
    chk("p64_idle_done", 64'(bus64.done), 64'd0);
    $display("pass64 dir=%0d complete", d);
  endtask

  initial begin
    logic [15:0] pat;
    logic [63:0] one;
    int          exp_addr;
    int          mstate;
    int          cyc;
    logic        s;

    do_reset();
    // Reset values
    chk("rst_addr", 64'(bus64.addr), 64'd0);
    chk("rst_wl", bus64.wl_sel, 64'd0);
    chk("rst_vld", 64'(bus64.addr_vld), 64'd0);
    chk("rst_last", 64'(bus64.last), 64'd0);
    chk("rst_busy", 64'(bus64.busy), 64'd0);
    chk("rst_done", 64'(bus64.done), 64'd0);
    chk("rst40_wl", 64'(bus40.wl_sel), 64'd0);
    // step_en in IDLE does nothing
    bus64.step_en = 1'b1;
    tick();
    chk("idle_step_vld", 64'(bus64.addr_vld), 64'd0);
    chk("idle_step_busy", 64'(bus64.busy), 64'd0);
    bus64.step_en = 1'b0;
    $display("reset checks complete");

    run64(1'b0);
    run64(1'b1);

    // Non-power-of-2 depth: terminal row 39.
    bus40.dir     = 1'b0;
    bus40.start   = 1'b1;
    bus40.step_en = 1'b1;
    tick();
    bus40.start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      one = 64'd1 << k;
      chk("p40_addr", 64'(bus40.addr), 64'(k));
      chk("p40_wl", 64'(bus40.wl_sel), one);
      chk("p40_last", 64'(bus40.last), 64'(k == 39));
      chk("p40_range", 64'(bus40.addr < 6'd40), 64'd1);
      tick();
    end
    chk("p40_done", 64'(bus40.done), 64'd1);
    chk("p40_done_vld", 64'(bus40.addr_vld), 64'd0);
    chk("p40_done_wl", 64'(bus40.wl_sel), 64'd0);
    bus40.step_en = 1'b0;
    tick();
    chk("p40_idle_busy", 64'(bus40.busy), 64'd0);
    $display("pass40 complete");

    // Stalled pass with spurious start/dir changes during RUN.
    pat           = 16'b1011_0010_1101_0110;
    bus64.dir     = 1'b0;
    bus64.start   = 1'b1;
    bus64.step_en = 1'b0;
    tick();
    exp_addr = 0;
    mstate   = 0;
    cyc      = 0;
    while (cyc < 400) begin
      if (mstate == 1) begin
        chk("stall_done", 64'(bus64.done), 64'd1);
        chk("stall_done_vld", 64'(bus64.addr_vld), 64'd0);
        bus64.start   = 1'b0;
        bus64.step_en = 1'b0;
        break;
      end
      one = 64'd1 << exp_addr;
      chk("stall_addr", 64'(bus64.addr), 64'(exp_addr));
      chk("stall_wl", bus64.wl_sel, one);
      chk("stall_last", 64'(bus64.last), 64'(exp_addr == 63));
      chk("stall_nodone", 64'(bus64.done), 64'd0);
      s             = pat[cyc % 16];
      bus64.step_en = s;
      bus64.start   = cyc[0];
      bus64.dir     = 1'b1;
      tick();
      if (s) begin
        if (exp_addr == 63) mstate = 1;
        else                exp_addr++;
      end
      cyc++;
    end
    chk("stall_timeout", 64'(cyc < 400), 64'd1);
    tick();
    chk("stall_idle_busy", 64'(bus64.busy), 64'd0);
    chk("stall_idle_done", 64'(bus64.done), 64'd0);
    $display("stalled pass complete after %0d cycles", cyc);

    // Reset mid-pass at row 20.
    bus64.dir     = 1'b0;
    bus64.start   = 1'b1;
    bus64.step_en = 1'b1;
    tick();
    bus64.start = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    chk("mrst_at20", 64'(bus64.addr), 64'd20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus64.step_en = 1'b0;
    chk("mrst_addr", 64'(bus64.addr), 64'd0);
    chk("mrst_wl", bus64.wl_sel, 64'd0);
    chk("mrst_vld", 64'(bus64.addr_vld), 64'd0);
    chk("mrst_busy", 64'(bus64.busy), 64'd0);
    chk("mrst_done", 64'(bus64.done), 64'd0);
    tick();
    chk("mrst_nodone", 64'(bus64.done), 64'd0);
    chk("mrst_idle", 64'(bus64.addr_vld), 64'd0);
    bus64.dir   = 1'b1;
    bus64.start = 1'b1;
    tick();
    bus64.start = 1'b0;
    chk("mrst_restart_addr", 64'(bus64.addr), 64'd63);
    chk("mrst_restart_wl", bus64.wl_sel, 64'h8000_0000_0000_0000);
    chk("mrst_restart_vld", 64'(bus64.addr_vld), 64'd1);
    chk("mrst_restart_last", 64'(bus64.last), 64'd0);
    $display("mid-pass reset complete");
    do_reset();

`ifdef ARF074B064E1R1W0CBBEHSAA4ACW_BIST_ADDR_SEQ_ABORT_EN
    // abort in IDLE has no effect, including alongside start.
    bus64.abort = 1'b1;
    tick();
    chk("ab_idle_vld", 64'(bus64.addr_vld), 64'd0);
    chk("ab_idle_busy", 64'(bus64.busy), 64'd0);
    bus64.dir   = 1'b0;
    bus64.start = 1'b1;
    tick();
    bus64.start = 1'b0;
    bus64.abort = 1'b0;
    chk("ab_start_vld", 64'(bus64.addr_vld), 64'd1);
    chk("ab_start_addr", 64'(bus64.addr), 64'd0);
    bus64.step_en = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    chk("ab_at10", 64'(bus64.addr), 64'd10);
    bus64.abort = 1'b1;
    tick();
    bus64.abort   = 1'b0;
    bus64.step_en = 1'b0;
    chk("ab_vld", 64'(bus64.addr_vld), 64'd0);
    chk("ab_busy", 64'(bus64.busy), 64'd0);
    chk("ab_addr", 64'(bus64.addr), 64'd0);
    chk("ab_wl", bus64.wl_sel, 64'd0);
    chk("ab_done", 64'(bus64.done), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ab_nodone", 64'(bus64.done), 64'd0);
    end
    $display("abort checks complete");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
